// File: rtl/predecode_queue_if.sv
// Handshake bundle between the fetch path, the predecode queue and the decode stage.
interface predecode_queue_if #(
  parameter int unsigned PC_W = 16
);
  logic            flush;
  logic [PC_W-1:0] flush_pc;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_opcode;
  logic [15:0]     out_operand;
  logic [1:0]      out_len;
  logic [PC_W-1:0] out_pc;
  logic            out_jam;

  modport master (
    output flush, flush_pc, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_operand, out_len, out_pc, out_jam
  );

  modport slave (
    input  flush, flush_pc, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_opcode, out_operand, out_len, out_pc, out_jam
  );
endinterface

// File: rtl/predecode_queue.sv
// Byte prefetch queue that predecodes the head opcode and hands out whole 1-3 byte instructions.
// Optional JAM opcode detection and halt: define PREDECODE_JAM_DETECT_EN.
module predecode_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  predecode_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  logic [7:0]  head_op_c;
  logic [7:0]  byte1_c;
  logic [7:0]  byte2_c;
  logic [1:0]  len_c;
  logic        jam_c;
  logic        halted_c;
  logic        in_ready_c;
  logic        out_valid_c;
  logic        push_c;
  logic        pop_c;

  // Length rule on the raw opcode bits: 1, 2 or 3 bytes.
  function automatic logic [1:0] predecode_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd2;
    if (op == 8'h00 || op == 8'h40 || op == 8'h60 ||
        (op & 8'b0000_1101) == 8'b0000_1000) begin
      len = 2'd1;
    end else if (op == 8'h20 ||
                 (op & 8'b0000_1100) == 8'b0000_1100 ||
                 (op & 8'b0001_1101) == 8'b0001_1001) begin
      len = 2'd3;
    end
    return len;
  endfunction

  assign head_op_c = mem_q[rd_ptr_q];
  assign byte1_c   = mem_q[rd_ptr_q + PTR_W'(1)];
  assign byte2_c   = mem_q[rd_ptr_q + PTR_W'(2)];

`ifdef PREDECODE_JAM_DETECT_EN
  logic halted_q, halted_d;

  always_comb begin
    case (head_op_c)
      8'h02, 8'h12, 8'h22, 8'h32, 8'h42, 8'h52,
      8'h62, 8'h72, 8'h92, 8'hB2, 8'hD2, 8'hF2: jam_c = 1'b1;
      default:                                 jam_c = 1'b0;
    endcase
  end

  assign len_c    = jam_c ? 2'd1 : predecode_len(head_op_c);
  assign halted_c = halted_q;
`else
  assign jam_c    = 1'b0;
  assign len_c    = predecode_len(head_op_c);
  assign halted_c = 1'b0;
`endif

  assign in_ready_c  = (count_q < CNT_W'(DEPTH)) && !halted_c;
  assign out_valid_c = (count_q >= CNT_W'(len_c)) && !bus.flush && !halted_c;
  assign push_c      = bus.in_valid && in_ready_c && !bus.flush;
  assign pop_c       = out_valid_c && bus.out_ready;

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_opcode  = head_op_c;
  assign bus.out_len     = len_c;
  assign bus.out_pc      = pc_q;
  assign bus.out_jam     = jam_c;
  // Operand bytes past the instruction length or past the filled region read as zero.
  assign bus.out_operand = {
    ((len_c == 2'd3) && (count_q >= CNT_W'(3))) ? byte2_c : 8'h00,
    ((len_c != 2'd1) && (count_q >= CNT_W'(2))) ? byte1_c : 8'h00
  };

  // Next-state: flush wins over any push or pop in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
`ifdef PREDECODE_JAM_DETECT_EN
    halted_d = halted_q;
`endif
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = bus.flush_pc;
`ifdef PREDECODE_JAM_DETECT_EN
      halted_d = 1'b0;
`endif
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(len_c);
        pc_d     = pc_q + PC_W'(len_c);
`ifdef PREDECODE_JAM_DETECT_EN
        if (jam_c) begin
          halted_d = 1'b1;
        end
`endif
      end
      count_d = count_q + CNT_W'(push_c) - (pop_c ? CNT_W'(len_c) : CNT_W'(0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= '0;
`ifdef PREDECODE_JAM_DETECT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
`ifdef PREDECODE_JAM_DETECT_EN
      halted_q <= halted_d;
`endif
    end
  end

  // Byte storage; cleared on reset so the head decodes as a 1-byte 0x00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_predecode_queue.sv
// Directed bench for predecode_queue (DEPTH=8, PC_W=16).
module tb_predecode_queue;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  predecode_queue_if #(.PC_W(16)) bus ();

  predecode_queue #(.DEPTH(8), .PC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
  endtask

  task automatic do_flush(input logic [15:0] pc);
    bus.flush    = 1'b1;
    bus.flush_pc = pc;
    tick();
    bus.flush    = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_opcode !== 8'h00) begin failures++; $display("FAIL reset_opcode got=%h exp=00", bus.out_opcode); end
    checks++; if (bus.out_operand !== 16'h0000) begin failures++; $display("FAIL reset_operand got=%h exp=0000", bus.out_operand); end
    checks++; if (bus.out_len !== 2'd1) begin failures++; $display("FAIL reset_len got=%0d exp=1", bus.out_len); end
    checks++; if (bus.out_pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", bus.out_pc); end
    checks++; if (bus.out_jam !== 1'b0) begin failures++; $display("FAIL reset_jam got=%b exp=0", bus.out_jam); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_flush(16'h0200);
    checks++; if (bus.out_pc !== 16'h0200) begin failures++; $display("FAIL basic_flush_pc got=%h exp=0200", bus.out_pc); end
    push_byte(8'hA9);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_partial_valid got=%b exp=0", bus.out_valid); end
    push_byte(8'h05);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_opcode !== 8'hA9) begin failures++; $display("FAIL basic_opcode got=%h exp=a9", bus.out_opcode); end
    checks++; if (bus.out_operand !== 16'h0005) begin failures++; $display("FAIL basic_operand got=%h exp=0005", bus.out_operand); end
    checks++; if (bus.out_len !== 2'd2) begin failures++; $display("FAIL basic_len got=%0d exp=2", bus.out_len); end
    checks++; if (bus.out_pc !== 16'h0200) begin failures++; $display("FAIL basic_pc got=%h exp=0200", bus.out_pc); end
    pop_one();
    checks++; if (bus.out_pc !== 16'h0202) begin failures++; $display("FAIL basic_pop_pc got=%h exp=0202", bus.out_pc); end
    checks++; if (dut.count_q !== 4'd0) begin failures++; $display("FAIL basic_pop_count got=%0d exp=0", dut.count_q); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_empty_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_len3();
    push_byte(8'h8D);
    push_byte(8'h00);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL len3_two_bytes_valid got=%b exp=0", bus.out_valid); end
    push_byte(8'h44);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL len3_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_len !== 2'd3) begin failures++; $display("FAIL len3_len got=%0d exp=3", bus.out_len); end
    checks++; if (bus.out_operand !== 16'h4400) begin failures++; $display("FAIL len3_operand got=%h exp=4400", bus.out_operand); end
    push_byte(8'hEA);
    pop_one();
    checks++; if (bus.out_opcode !== 8'hEA) begin failures++; $display("FAIL len3_next_opcode got=%h exp=ea", bus.out_opcode); end
    checks++; if (bus.out_len !== 2'd1) begin failures++; $display("FAIL len3_next_len got=%0d exp=1", bus.out_len); end
    checks++; if (bus.out_operand !== 16'h0000) begin failures++; $display("FAIL len3_next_operand got=%h exp=0000", bus.out_operand); end
    checks++; if (bus.out_pc !== 16'h0205) begin failures++; $display("FAIL len3_pc got=%h exp=0205", bus.out_pc); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL len3_next_valid got=%b exp=1", bus.out_valid); end
    pop_one();
    checks++; if (bus.out_pc !== 16'h0206) begin failures++; $display("FAIL len3_pc2 got=%h exp=0206", bus.out_pc); end
  endtask

  task automatic test_full();
    do_flush(16'h0300);
    for (int i = 0; i < 8; i++) push_byte(8'hEA);
    checks++; if (dut.count_q !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", dut.count_q); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    // held push while full is ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    tick();
    checks++; if (dut.count_q !== 4'd8) begin failures++; $display("FAIL full_held_push got=%0d exp=8", dut.count_q); end
    // pop while full: push still refused this cycle, count drops
    bus.out_ready = 1'b1;
    tick();
    checks++; if (dut.count_q !== 4'd7) begin failures++; $display("FAIL full_pop_count got=%0d exp=7", dut.count_q); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_back got=%b exp=1", bus.in_ready); end
    bus.in_data = 8'hEA;
    tick();
    checks++; if (dut.count_q !== 4'd7) begin failures++; $display("FAIL full_push_pop_count got=%0d exp=7", dut.count_q); end
    checks++; if (bus.out_pc !== 16'h0302) begin failures++; $display("FAIL full_pc got=%h exp=0302", bus.out_pc); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
  endtask

  task automatic test_wrap();
    do_flush(16'h1000);
    for (int i = 0; i < 7; i++) push_byte(8'hEA);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.out_ready = 1'b0;
    #1;
    checks++; if (dut.rd_ptr_q !== 3'd7) begin failures++; $display("FAIL wrap_rd_ptr got=%0d exp=7", dut.rd_ptr_q); end
    push_byte(8'h20);
    push_byte(8'h34);
    checks++; if (bus.out_operand !== 16'h0034) begin failures++; $display("FAIL wrap_mask_operand got=%h exp=0034", bus.out_operand); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL wrap_partial_valid got=%b exp=0", bus.out_valid); end
    push_byte(8'h12);
    checks++; if (bus.out_opcode !== 8'h20) begin failures++; $display("FAIL wrap_opcode got=%h exp=20", bus.out_opcode); end
    checks++; if (bus.out_operand !== 16'h1234) begin failures++; $display("FAIL wrap_operand got=%h exp=1234", bus.out_operand); end
    checks++; if (bus.out_len !== 2'd3) begin failures++; $display("FAIL wrap_len got=%0d exp=3", bus.out_len); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", bus.out_valid); end
    pop_one();
    checks++; if (dut.rd_ptr_q !== 3'd2) begin failures++; $display("FAIL wrap_rd_ptr_end got=%0d exp=2", dut.rd_ptr_q); end
    checks++; if (bus.out_pc !== 16'h100A) begin failures++; $display("FAIL wrap_pc got=%h exp=100a", bus.out_pc); end
  endtask

  task automatic test_flush();
    push_byte(8'hEA);
    bus.flush     = 1'b1;
    bus.flush_pc  = 16'hFFFE;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA9;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_cycle_valid got=%b exp=0", bus.out_valid); end
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (dut.count_q !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", dut.count_q); end
    checks++; if (dut.wr_ptr_q !== 3'd0) begin failures++; $display("FAIL flush_wr_ptr got=%0d exp=0", dut.wr_ptr_q); end
    checks++; if (bus.out_pc !== 16'hFFFE) begin failures++; $display("FAIL flush_pc got=%h exp=fffe", bus.out_pc); end
    push_byte(8'h00);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_brk_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_len !== 2'd1) begin failures++; $display("FAIL flush_brk_len got=%0d exp=1", bus.out_len); end
    pop_one();
    checks++; if (bus.out_pc !== 16'hFFFF) begin failures++; $display("FAIL flush_pc_inc got=%h exp=ffff", bus.out_pc); end
    push_byte(8'h00);
    pop_one();
    checks++; if (bus.out_pc !== 16'h0000) begin failures++; $display("FAIL flush_pc_wrap got=%h exp=0000", bus.out_pc); end
  endtask

  task automatic test_jam();
    do_flush(16'h0400);
    push_byte(8'h02);
`ifdef PREDECODE_JAM_DETECT_EN
    checks++; if (bus.out_jam !== 1'b1) begin failures++; $display("FAIL jam_flag got=%b exp=1", bus.out_jam); end
    checks++; if (bus.out_len !== 2'd1) begin failures++; $display("FAIL jam_len got=%0d exp=1", bus.out_len); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL jam_valid got=%b exp=1", bus.out_valid); end
    push_byte(8'hA9);
    pop_one();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL jam_halt_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL jam_halt_in_ready got=%b exp=0", bus.in_ready); end
    push_byte(8'h05);
    push_byte(8'h06);
    checks++; if (dut.count_q !== 4'd1) begin failures++; $display("FAIL jam_halt_count got=%0d exp=1", dut.count_q); end
    checks++; if (bus.out_pc !== 16'h0401) begin failures++; $display("FAIL jam_pc got=%h exp=0401", bus.out_pc); end
    do_flush(16'h0500);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL jam_flush_in_ready got=%b exp=1", bus.in_ready); end
    push_byte(8'hEA);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL jam_flush_valid got=%b exp=1", bus.out_valid); end
`else
    checks++; if (bus.out_jam !== 1'b0) begin failures++; $display("FAIL nojam_flag got=%b exp=0", bus.out_jam); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL nojam_partial_valid got=%b exp=0", bus.out_valid); end
    push_byte(8'hA9);
    checks++; if (bus.out_len !== 2'd2) begin failures++; $display("FAIL nojam_len got=%0d exp=2", bus.out_len); end
    checks++; if (bus.out_operand !== 16'h00A9) begin failures++; $display("FAIL nojam_operand got=%h exp=00a9", bus.out_operand); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL nojam_valid got=%b exp=1", bus.out_valid); end
    pop_one();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL nojam_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_pc !== 16'h0402) begin failures++; $display("FAIL nojam_pc got=%h exp=0402", bus.out_pc); end
`endif
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.flush_pc  = 16'h0000;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_len3();
    test_full();
    test_wrap();
    test_flush();
    test_jam();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
